// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states, access decode.
// Alignment behaviour depends on DMEM_ALIGN_TRAP_EN (defined: misaligned/illegal -> error).
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int OP_UNS_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic       err;
  } acc_t;

  function automatic acc_t decode_access(input logic [2:0] opcode, input logic [1:0] lo);
    acc_t a;
    a.size = opcode[1:0];
    a.uns  = opcode[OP_UNS_BIT];
    a.lane = lo;
    a.err  = 1'b0;
`ifdef DMEM_ALIGN_TRAP_EN
    case (a.size)
      SZ_HALF: a.err = lo[0];
      SZ_WORD: a.err = |lo;
      SZ_ILL:  a.err = 1'b1;
      default: a.err = 1'b0;
    endcase
`else
    // Without trapping, the illegal size behaves as a word and low bits are dropped.
    if (a.size == SZ_ILL) a.size = SZ_WORD;
    case (a.size)
      SZ_HALF: a.lane = {lo[1], 1'b0};
      SZ_WORD: a.lane = 2'b00;
      default: a.lane = lo;
    endcase
`endif
    return a;
  endfunction

  function automatic logic [3:0] byte_enables(input acc_t a);
    logic [3:0] be;
    case (a.size)
      SZ_BYTE: be = 4'b0001 << a.lane;
      SZ_HALF: be = a.lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
// Contents are not reset; a write and read to the same word returns the old data.
module dmem_ram #(
  parameter int B  = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic [B/8-1:0]  we,
  input  logic [AW-1:0]   addr,
  input  logic [B-1:0]    wdata,
  output logic [B-1:0]    rdata
);

  logic [B-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < B/8; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, WAIT wait states, lane steering
// and load extension. DMEM_ALIGN_TRAP_EN enables alignment/illegal-size error responses.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// BUSY    | counting wait states down to zero
// RESP    | resp_valid pulse, RAM write/read already done
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int B    = 32,
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [5:0]   req_opcode,
  input  logic [B-1:0] req_addr,
  input  logic [B-1:0] req_wdata,
  output logic         resp_valid,
  output logic [B-1:0] resp_rdata,
  output logic         resp_err
);

  localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [2:0]    lat_opcode;
  logic [AW+1:0] lat_addr;
  logic [B-1:0]  lat_wdata;

  logic          accept;
  logic          go_resp;
  logic          cur_write;
  logic [2:0]    cur_opcode;
  logic [AW+1:0] cur_addr;
  logic [B-1:0]  cur_wdata;
  acc_t          cur_acc;
  logic [3:0]    ram_we;
  logic [B-1:0]  ram_wdata;
  logic [B-1:0]  ram_rdata;
  logic [B-1:0]  shifted;
  logic [B-1:0]  load_ext;
  logic          unused_req_bits;

  assign unused_req_bits = ^{req_addr[B-1:AW+2], req_opcode[5:3]};

  assign accept = req_valid && req_ready;

  // The RAM port sees the incoming request in IDLE (needed when WAIT=0), else the latch.
  always_comb begin
    cur_write  = lat_write;
    cur_opcode = lat_opcode;
    cur_addr   = lat_addr;
    cur_wdata  = lat_wdata;
    if (state == ST_IDLE) begin
      cur_write  = req_write;
      cur_opcode = req_opcode[2:0];
      cur_addr   = req_addr[AW+1:0];
      cur_wdata  = req_wdata;
    end
  end

  assign cur_acc = decode_access(cur_opcode, cur_addr[1:0]);

  assign go_resp = ((state == ST_IDLE) && accept && (WAIT == 0)) ||
                   ((state == ST_BUSY) && (cnt == 4'd0));

  always_comb begin
    ram_we = 4'b0000;
    if (go_resp && cur_write && !cur_acc.err && reset_n) ram_we = byte_enables(cur_acc);
  end

  always_comb begin
    case (cur_acc.size)
      SZ_BYTE: ram_wdata = {(B/8){cur_wdata[7:0]}};
      SZ_HALF: ram_wdata = {(B/16){cur_wdata[15:0]}};
      default: ram_wdata = cur_wdata;
    endcase
  end

  dmem_ram #(.B(B), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign shifted = ram_rdata >> {cur_acc.lane, 3'b000};

  always_comb begin
    case (cur_acc.size)
      SZ_BYTE: load_ext = {{(B-8){~cur_acc.uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{(B-16){~cur_acc.uns & shifted[15]}}, shifted[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  assign resp_rdata = (resp_valid && !lat_write && !cur_acc.err) ? load_ext : '0;
  assign resp_err   = resp_valid && cur_acc.err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      lat_write  <= 1'b0;
      lat_opcode <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write  <= req_write;
            lat_opcode <= req_opcode[2:0];
            lat_addr   <= req_addr[AW+1:0];
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (WAIT == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses, negedge monitor checks.
module tb_dmem_responder;

  localparam int WAIT_C = 1;
  localparam int AW_C   = 10;
`ifdef DMEM_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_ILL = 6'h22, OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.B(32), .AW(AW_C), .WAIT(WAIT_C)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, 32'(resp_err), 32'(mon_e.err));
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
        check({mon_e.name, "_ready_low"}, 32'(req_ready), 32'd0);
      end
    end
  end

  // Leaves the caller at a negedge where req_ready is high (or the bound expired).
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic push_exp(input string name, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.due   = cyc + 1 + WAIT_C;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic issue(input string name, input logic wr, input logic [5:0] opc,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    wait_ready();
    req_valid  = 1'b1;
    req_write  = wr;
    req_opcode = opc;
    req_addr   = addr;
    req_wdata  = wdata;
    push_exp(name, exp_rdata, exp_err);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  int acc_cyc[3];

  initial begin
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("sw10",   1'b1, OP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    issue("lw10",   1'b0, OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    issue("sb11",   1'b1, OP_SB,  32'h11, 32'h80,       32'h0,        1'b0);
    issue("lw10b",  1'b0, OP_LW,  32'h10, 32'h0,        32'hDEAD80EF, 1'b0);
    issue("lb11",   1'b0, OP_LB,  32'h11, 32'h0,        32'hFFFFFF80, 1'b0);
    issue("lbu11",  1'b0, OP_LBU, 32'h11, 32'h0,        32'h00000080, 1'b0);
    issue("sh12",   1'b1, OP_SH,  32'h12, 32'h8001,     32'h0,        1'b0);
    issue("lh12",   1'b0, OP_LH,  32'h12, 32'h0,        32'hFFFF8001, 1'b0);
    issue("lhu12",  1'b0, OP_LHU, 32'h12, 32'h0,        32'h00008001, 1'b0);
    issue("lhu10",  1'b0, OP_LHU, 32'h10, 32'h0,        32'h000080EF, 1'b0);
    issue("lw13",   1'b0, OP_LW,  32'h13, 32'h0, TRAP ? 32'h0 : 32'h800180EF, TRAP);
    issue("lwwrap", 1'b0, OP_LW,  32'h1010, 32'h0,      32'h800180EF, 1'b0);
    issue("lb10",   1'b0, OP_LB,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    issue("lh11",   1'b0, OP_LH,  32'h11, 32'h0, TRAP ? 32'h0 : 32'hFFFF80EF, TRAP);
    issue("ill10",  1'b0, OP_ILL, 32'h10, 32'h0, TRAP ? 32'h0 : 32'h800180EF, TRAP);
    issue("sw13",   1'b1, OP_SW,  32'h13, 32'h55555555, 32'h0,        TRAP);
    issue("lw10c",  1'b0, OP_LW,  32'h10, 32'h0, TRAP ? 32'h800180EF : 32'h55555555, 1'b0);
    issue("sb17",   1'b1, OP_SB,  32'h17, 32'h7F,       32'h0,        1'b0);
    issue("lbu17",  1'b0, OP_LBU, 32'h17, 32'h0,        32'h0000007F, 1'b0);
    issue("lb17",   1'b0, OP_LB,  32'h17, 32'h0,        32'h0000007F, 1'b0);
    drain();

    // req_valid held high across three back-to-back loads
    req_write  = 1'b0;
    req_opcode = OP_LBU;
    req_addr   = 32'h17;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      req_valid = 1'b1;
      push_exp("held", 32'h0000007F, 1'b0);
      acc_cyc[k] = cyc;
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    check("spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(WAIT_C + 2));
    check("spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(WAIT_C + 2));
    drain();

    // reset during an in-flight store drops it
    issue("sw20", 1'b1, OP_SW, 32'h20, 32'h11223344, 32'h0, 1'b0);
    drain();
    wait_ready();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_opcode = OP_SW;
    req_addr   = 32'h20;
    req_wdata  = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    check("midrst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue("lw20", 1'b0, OP_LW, 32'h20, 32'h0, (WAIT_C > 0) ? 32'h11223344 : 32'hAAAAAAAA, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
